cache_bus_arbiter: RTL and testbench
====================================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2, number of cache-side requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-004 Parameter ARB_MODE, default RR, arbitration mode: RR (round-robin) or FIXED (lowest index wins).
REQ-005 One clock and one reset: reset is synchronous and active-low.
REQ-006 CLK  in  1  clock; all state updates on rising edge.
REQ-007 nRST  in  1  synchronous active-low reset.
REQ-008 req_addr  in  NUM_PORTS x ADDR_W  per-port request address.
REQ-009 req_wdata  in  NUM_PORTS x DATA_W  per-port write data.
REQ-010 req_ren, req_wen  in  NUM_PORTS  per-port read/write strobes.
REQ-011 req_byte_en  in  NUM_PORTS x DATA_W/8  per-port byte enables.
REQ-012 req_rdata  out  NUM_PORTS x DATA_W  read data; all ports receive mem_rdata.
REQ-013 req_busy  out  NUM_PORTS  per-port busy; low for exactly one cycle marks completion.
REQ-014 mem_addr, mem_wdata, mem_byte_en, mem_ren, mem_wen  out  memory-side generic bus request.
REQ-015 mem_rdata  in  DATA_W; mem_busy  in  1  memory-side response.

Function
REQ-016 A port requests when req_ren or req_wen is high.
REQ-017 States: IDLE, ACTIVE.
REQ-018 IDLE: mem_ren=mem_wen=0; if any port requests, the winner is registered into grant and state becomes ACTIVE next cycle.
REQ-019 RR mode: winner is first requesting port at or after rr_ptr, wrapping NUM_PORTS-1 -> 0.
REQ-020 FIXED mode: winner is lowest-index requesting port; rr_ptr unused.
REQ-021 ACTIVE: mem_* request signals equal the granted port's signals combinationally.
REQ-022 ACTIVE: req_busy[grant]=mem_busy; all other ports req_busy=1.
REQ-023 IDLE: all req_busy=1.
REQ-024 Completion: ACTIVE, granted port requesting, mem_busy=0 -> req_busy[grant]=0 that cycle; next state IDLE; rr_ptr <= (grant+1) mod NUM_PORTS.
REQ-025 Arbitration overhead: one IDLE cycle between consecutive transactions; minimum port latency = 1 + memory latency.
REQ-026 Withdrawal: granted port drops ren and wen in ACTIVE -> mem strobes drop same cycle, IDLE next cycle, rr_ptr unchanged.
REQ-027 Grant never changes while ACTIVE, regardless of other ports' requests.
REQ-028 Simultaneous ren and wen on a port are forwarded unmodified.
REQ-029 rr_ptr and grant are $clog2(NUM_PORTS) bits (minimum 1); wrap uses modulo, not overflow, for non-power-of-two NUM_PORTS.

Reset
REQ-030 nRST low at a clock edge: state=IDLE, grant=0, rr_ptr=0.
REQ-031 Outputs during/after reset: mem_ren=mem_wen=0, all req_busy=1.
REQ-032 Reset mid-transaction abandons it; no completion pulse is generated.

Structure
REQ-033 Package cache_arb_pkg holds arb_state_t (IDLE, ACTIVE) and arb_mode_t (RR, FIXED).
REQ-034 Sub-module rr_priority_picker (request vector, pointer, mode -> one-hot/index winner, valid).

Verification
REQ-035 NUM_PORTS=2, RR; both read from reset: port0 granted, completes; port1 granted next; port0 again after that (alternation 0,1,0).
REQ-036 FIXED, NUM_PORTS=4, ports 1 and 3 continuously request: port1 granted on every arbitration; port3 starves.
REQ-037 Port0 write addr 0x100, wdata 0xDEADBEEF, byte_en 0xF, mem_busy high 3 cycles: mem_* match port0 exactly, req_busy[0] low exactly one cycle.
REQ-038 NUM_PORTS=3, RR, rr_ptr=2, ports 0 and 1 requesting: port0 granted (wrap-around).
REQ-039 Granted port drops ren mid-transaction: mem_ren drops same cycle, IDLE next, rr_ptr unchanged, no completion pulse.
REQ-040 nRST low during ACTIVE: next cycle IDLE, mem_ren=mem_wen=0, all req_busy=1, rr_ptr=0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types for the cache bus arbiter: FSM states, arbitration
// modes and the index-width helper used for grant and rr_ptr.
package cache_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        RR    = 1'b0,
        FIXED = 1'b1
    } arb_mode_t;

    // Index width for a port number, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Picks one requester: first set bit at or after ptr (RR, wrapping)
// or lowest set bit (FIXED).
// Ports: req (request vector), ptr (rotation start), mode,
//        onehot / idx (winner), valid (any request present).
module rr_priority_picker
    import cache_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    input  arb_mode_t            mode,
    output logic [NUM_PORTS-1:0] onehot,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    int start;
    int k;

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        start  = (mode == FIXED) ? 0 : int'(ptr);
        k      = 0;
        // Scan NUM_PORTS positions from start; modulo keeps the wrap
        // correct for non-power-of-two port counts.
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (start + i) % NUM_PORTS;
            if (!valid && req[k]) begin
                valid     = 1'b1;
                idx       = IDX_W'(k);
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Arbitrates NUM_PORTS cache-side requesters onto one memory bus.
// Ports: CLK, nRST (sync active-low); per-port req_* in, req_rdata /
//        req_busy out; mem_* request out, mem_rdata / mem_busy in.
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int        NUM_PORTS = 2,
    parameter int        ADDR_W    = 32,
    parameter int        DATA_W    = 32,
    parameter arb_mode_t ARB_MODE  = RR
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]            req_ren,
    input  logic [NUM_PORTS-1:0]            req_wen,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   req_byte_en,
    output logic [NUM_PORTS*DATA_W-1:0]     req_rdata,
    output logic [NUM_PORTS-1:0]            req_busy,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    output logic [DATA_W/8-1:0]             mem_byte_en,
    output logic                            mem_ren,
    output logic                            mem_wen,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            mem_busy
);

    localparam int IDX_W = idx_width(NUM_PORTS);
    localparam int BE_W  = DATA_W / 8;

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     grant, grant_nxt;
    logic [NUM_PORTS-1:0] grant_oh, grant_oh_nxt;
    logic [IDX_W-1:0]     rr_ptr, ptr_nxt;
    logic [IDX_W-1:0]     wrap_ptr;

    logic [NUM_PORTS-1:0] req_any;
    logic [NUM_PORTS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;

    assign req_any  = req_ren | req_wen;
    assign wrap_ptr = IDX_W'((int'(grant) + 1) % NUM_PORTS);

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req    (req_any),
        .ptr    (rr_ptr),
        .mode   (ARB_MODE),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            grant    <= '0;
            grant_oh <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            grant_oh <= grant_oh_nxt;
            rr_ptr   <= ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant;
        grant_oh_nxt = grant_oh;
        ptr_nxt      = rr_ptr;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt    = ACTIVE;
                    grant_nxt    = pick_idx;
                    grant_oh_nxt = pick_oh;
                end
            end
            ACTIVE: begin
                // Withdrawal leaves the rotation pointer untouched.
                if (!req_any[grant]) begin
                    state_nxt = IDLE;
                end else if (!mem_busy) begin
                    state_nxt = IDLE;
                    if (ARB_MODE == RR) begin
                        ptr_nxt = wrap_ptr;
                    end
                end
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_addr    = req_addr[int'(grant)*ADDR_W +: ADDR_W];
        mem_wdata   = req_wdata[int'(grant)*DATA_W +: DATA_W];
        mem_byte_en = req_byte_en[int'(grant)*BE_W +: BE_W];
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        req_busy    = '1;
        if (state == ACTIVE) begin
            mem_ren = req_ren[grant];
            mem_wen = req_wen[grant];
            // Only a still-requesting granted port sees busy drop,
            // so a withdrawn port never gets a completion pulse.
            req_busy = ~(grant_oh & req_any & {NUM_PORTS{~mem_busy}});
        end
    end

    assign req_rdata = {NUM_PORTS{mem_rdata}};

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: three instances
// (2-port RR, 4-port FIXED, 3-port RR) sharing one clock.
module tb_cache_bus_arbiter;
    import cache_arb_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance A: 2 ports, RR
    logic [63:0] a_addr, a_wdata, a_rdata;
    logic [1:0]  a_ren, a_wen, a_busy;
    logic [7:0]  a_be;
    logic [31:0] a_maddr, a_mwdata, a_mrdata;
    logic [3:0]  a_mbe;
    logic        a_mren, a_mwen, a_mbusy;

    // Instance B: 4 ports, FIXED
    logic [127:0] b_addr, b_wdata, b_rdata;
    logic [3:0]   b_ren, b_wen, b_busy;
    logic [15:0]  b_be;
    logic [31:0]  b_maddr, b_mwdata, b_mrdata;
    logic [3:0]   b_mbe;
    logic         b_mren, b_mwen, b_mbusy;

    // Instance C: 3 ports, RR
    logic [95:0] c_addr, c_wdata, c_rdata;
    logic [2:0]  c_ren, c_wen, c_busy;
    logic [11:0] c_be;
    logic [31:0] c_maddr, c_mwdata, c_mrdata;
    logic [3:0]  c_mbe;
    logic        c_mren, c_mwen, c_mbusy;

    cache_bus_arbiter #(.NUM_PORTS(2), .ARB_MODE(RR)) u_a (
        .CLK(clk), .nRST(nrst),
        .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ren(a_ren), .req_wen(a_wen), .req_byte_en(a_be),
        .req_rdata(a_rdata), .req_busy(a_busy),
        .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_byte_en(a_mbe), .mem_ren(a_mren), .mem_wen(a_mwen),
        .mem_rdata(a_mrdata), .mem_busy(a_mbusy)
    );

    cache_bus_arbiter #(.NUM_PORTS(4), .ARB_MODE(FIXED)) u_b (
        .CLK(clk), .nRST(nrst),
        .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ren(b_ren), .req_wen(b_wen), .req_byte_en(b_be),
        .req_rdata(b_rdata), .req_busy(b_busy),
        .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_byte_en(b_mbe), .mem_ren(b_mren), .mem_wen(b_mwen),
        .mem_rdata(b_mrdata), .mem_busy(b_mbusy)
    );

    cache_bus_arbiter #(.NUM_PORTS(3), .ARB_MODE(RR)) u_c (
        .CLK(clk), .nRST(nrst),
        .req_addr(c_addr), .req_wdata(c_wdata),
        .req_ren(c_ren), .req_wen(c_wen), .req_byte_en(c_be),
        .req_rdata(c_rdata), .req_busy(c_busy),
        .mem_addr(c_maddr), .mem_wdata(c_mwdata),
        .mem_byte_en(c_mbe), .mem_ren(c_mren), .mem_wen(c_mwen),
        .mem_rdata(c_mrdata), .mem_busy(c_mbusy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        a_ren = '1; b_ren = '1; c_ren = '1;
        repeat (2) cyc();
        tests++;
        if ({a_mren, a_mwen, a_busy} !== 4'b0011) begin
            fails++;
            $display("FAIL reset_a got %b want 0011", {a_mren, a_mwen, a_busy});
        end
        tests++;
        if ({b_mren, b_mwen, b_busy} !== 6'b001111) begin
            fails++;
            $display("FAIL reset_b got %b want 001111", {b_mren, b_mwen, b_busy});
        end
        tests++;
        if ({c_mren, c_mwen, c_busy} !== 5'b00111) begin
            fails++;
            $display("FAIL reset_c got %b want 00111", {c_mren, c_mwen, c_busy});
        end
        a_ren = '0; b_ren = '0; c_ren = '0;
        nrst = 1'b1;
        cyc();
    endtask

    task automatic test_rr_alternation();
        logic [31:0] exp_addr;
        logic [1:0]  exp_busy;
        int          g;
        a_addr = {32'h0000_00B0, 32'h0000_00A0};
        a_mbusy = 1'b0;
        a_mrdata = 32'h1234_5678;
        a_ren = 2'b11;
        #1;
        tests++;
        if ({a_mren, a_busy} !== 3'b011) begin
            fails++;
            $display("FAIL rr_idle got %b want 011", {a_mren, a_busy});
        end
        for (int n = 0; n < 3; n++) begin
            g = (n == 1) ? 1 : 0;
            exp_addr = (g == 1) ? 32'hB0 : 32'hA0;
            exp_busy = (g == 1) ? 2'b01 : 2'b10;
            cyc();
            tests++;
            if ({a_mren, a_maddr, a_busy} !== {1'b1, exp_addr, exp_busy}) begin
                fails++;
                $display("FAIL rr_grant%0d got ren=%b addr=%h busy=%b want addr=%h busy=%b",
                         n, a_mren, a_maddr, a_busy, exp_addr, exp_busy);
            end
            cyc();
            tests++;
            if ({a_mren, a_busy} !== 3'b011) begin
                fails++;
                $display("FAIL rr_gap%0d got %b want 011", n, {a_mren, a_busy});
            end
        end
        tests++;
        if (a_rdata !== {2{32'h1234_5678}}) begin
            fails++;
            $display("FAIL rdata_bcast got %h want %h", a_rdata, {2{32'h1234_5678}});
        end
        a_ren = 2'b00;
    endtask

    task automatic test_write();
        int lows = 0;
        logic [1:0] exp_busy;
        a_addr  = {32'h0000_0200, 32'h0000_0100};
        a_wdata = {32'h5555_AAAA, 32'hDEAD_BEEF};
        a_be    = 8'h3F;
        a_wen   = 2'b01;
        a_mbusy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 3) a_mbusy = 1'b0;
            #1;
            exp_busy = (i == 3) ? 2'b10 : 2'b11;
            if (a_busy[0] === 1'b0) lows++;
            tests++;
            if ({a_mren, a_mwen, a_maddr, a_mwdata, a_mbe, a_busy} !==
                {1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, exp_busy}) begin
                fails++;
                $display("FAIL write_c%0d got r=%b w=%b a=%h d=%h be=%h busy=%b want busy=%b",
                         i, a_mren, a_mwen, a_maddr, a_mwdata, a_mbe, a_busy, exp_busy);
            end
        end
        cyc();
        a_wen = 2'b00;
        #1;
        if (a_busy[0] === 1'b0) lows++;
        tests++;
        if ({a_mwen, a_busy} !== 3'b011) begin
            fails++;
            $display("FAIL write_idle got %b want 011", {a_mwen, a_busy});
        end
        tests++;
        if (lows != 1) begin
            fails++;
            $display("FAIL write_pulse got %0d low cycles want 1", lows);
        end
    endtask

    task automatic test_fixed_starve();
        b_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0};
        b_ren = 4'b1010;
        b_wen = 4'b0010;
        b_mbusy = 1'b0;
        for (int n = 0; n < 3; n++) begin
            cyc();
            tests++;
            if ({b_mren, b_mwen, b_maddr, b_busy} !== {2'b11, 32'h1000, 4'b1101}) begin
                fails++;
                $display("FAIL fixed_grant%0d got r=%b w=%b addr=%h busy=%b want 1 1 1000 1101",
                         n, b_mren, b_mwen, b_maddr, b_busy);
            end
            cyc();
        end
        b_mbusy = 1'b1;
        cyc();
        b_ren = 4'b1011;
        cyc();
        tests++;
        if ({b_maddr, b_busy} !== {32'h1000, 4'b1111}) begin
            fails++;
            $display("FAIL fixed_hold got addr=%h busy=%b want 1000 1111", b_maddr, b_busy);
        end
        b_mbusy = 1'b0;
        #1;
        tests++;
        if (b_busy !== 4'b1101) begin
            fails++;
            $display("FAIL fixed_done got %b want 1101", b_busy);
        end
        b_ren = '0;
        b_wen = '0;
        cyc();
    endtask

    task automatic test_wrap();
        c_addr = {32'hC2, 32'hC1, 32'hC0};
        c_mbusy = 1'b0;
        c_ren = 3'b010;
        cyc();
        tests++;
        if ({c_maddr, c_busy} !== {32'hC1, 3'b101}) begin
            fails++;
            $display("FAIL wrap_seed got addr=%h busy=%b want c1 101", c_maddr, c_busy);
        end
        c_ren = 3'b011;
        cyc();
        cyc();
        tests++;
        if ({c_mren, c_maddr, c_busy} !== {1'b1, 32'hC0, 3'b110}) begin
            fails++;
            $display("FAIL wrap_p0 got ren=%b addr=%h busy=%b want 1 c0 110",
                     c_mren, c_maddr, c_busy);
        end
        cyc();
        cyc();
        tests++;
        if ({c_maddr, c_busy} !== {32'hC1, 3'b101}) begin
            fails++;
            $display("FAIL wrap_p1 got addr=%h busy=%b want c1 101", c_maddr, c_busy);
        end
        cyc();
        c_ren = 3'b000;
    endtask

    task automatic test_withdraw();
        c_ren = 3'b001;
        c_mbusy = 1'b1;
        cyc();
        tests++;
        if ({c_mren, c_maddr, c_busy} !== {1'b1, 32'hC0, 3'b111}) begin
            fails++;
            $display("FAIL wd_grant got ren=%b addr=%h busy=%b want 1 c0 111",
                     c_mren, c_maddr, c_busy);
        end
        c_ren = 3'b000;
        c_mbusy = 1'b0;
        #1;
        tests++;
        if ({c_mren, c_busy} !== 4'b0111) begin
            fails++;
            $display("FAIL wd_drop got %b want 0111", {c_mren, c_busy});
        end
        cyc();
        c_ren = 3'b111;
        #1;
        tests++;
        if ({c_mren, c_busy} !== 4'b0111) begin
            fails++;
            $display("FAIL wd_idle got %b want 0111", {c_mren, c_busy});
        end
        cyc();
        tests++;
        if ({c_maddr, c_busy} !== {32'hC2, 3'b011}) begin
            fails++;
            $display("FAIL wd_ptr got addr=%h busy=%b want c2 011", c_maddr, c_busy);
        end
        cyc();
        c_ren = 3'b000;
    endtask

    task automatic test_reset_mid();
        c_ren = 3'b010;
        c_mbusy = 1'b0;
        cyc();
        cyc();
        c_ren = 3'b001;
        c_mbusy = 1'b1;
        cyc();
        tests++;
        if ({c_maddr, c_busy} !== {32'hC0, 3'b111}) begin
            fails++;
            $display("FAIL rst_pre got addr=%h busy=%b want c0 111", c_maddr, c_busy);
        end
        nrst = 1'b0;
        cyc();
        tests++;
        if ({c_mren, c_mwen, c_busy} !== 5'b00111) begin
            fails++;
            $display("FAIL rst_mid got %b want 00111", {c_mren, c_mwen, c_busy});
        end
        nrst = 1'b1;
        c_mbusy = 1'b0;
        c_ren = 3'b110;
        cyc();
        tests++;
        if ({c_mren, c_maddr, c_busy} !== {1'b1, 32'hC1, 3'b101}) begin
            fails++;
            $display("FAIL rst_ptr got ren=%b addr=%h busy=%b want 1 c1 101",
                     c_mren, c_maddr, c_busy);
        end
        c_ren = 3'b000;
    endtask

    initial begin
        a_addr = '0; a_wdata = '0; a_ren = '0; a_wen = '0; a_be = '0;
        a_mrdata = '0; a_mbusy = 1'b0;
        b_addr = '0; b_wdata = '0; b_ren = '0; b_wen = '0; b_be = '0;
        b_mrdata = '0; b_mbusy = 1'b0;
        c_addr = '0; c_wdata = '0; c_ren = '0; c_wen = '0; c_be = '0;
        c_mrdata = '0; c_mbusy = 1'b0;
        test_reset();
        test_rr_alternation();
        test_write();
        test_fixed_starve();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
